// File: rtl/fsm_pkg.sv
// Shared definitions for the per-channel transition-detecting FSM.
package fsm_pkg;

    // Gray-adjacent encoding; bit 1 is the debounced level.
    typedef enum logic [1:0] {
        ST_LOW   = 2'b00,
        ST_CHK_H = 2'b01,
        ST_HIGH  = 2'b11,
        ST_CHK_L = 2'b10
    } state_t;

    // Bits needed to hold a count of 0..hold (ceil(log2(hold+1))), minimum 1.
    function automatic int unsigned cnt_width(input int unsigned hold);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((33'd1 << i) <= 33'(hold)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/edge_fsm_chan.sv
// One channel: debounce FSM with hold counter and registered k1/k2/lvl.
module edge_fsm_chan
    import fsm_pkg::*;
#(
    parameter int unsigned HOLD = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic sticky,
    input  logic clr,
    output logic k1,
    output logic k2,
    output logic lvl
);

    localparam int unsigned     CW     = cnt_width(HOLD);
    localparam logic [CW-1:0]   HOLD_C = CW'(HOLD);
    localparam logic [CW-1:0]   ONE_C  = CW'(1);
    localparam logic [CW-1:0]   ZERO_C = CW'(0);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_done;
    logic            w_rise;
    logic            w_fall;
    logic            r_k1;
    logic            r_k2;
    logic            w_k1_nxt;
    logic            w_k2_nxt;

    assign w_cnt_inc = r_cnt + ONE_C;
    assign w_done    = (w_cnt_inc == HOLD_C);

    // State, counter and event registers; reset discards any check in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LOW;
            r_cnt   <= ZERO_C;
            r_k1    <= 1'b0;
            r_k2    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k1    <= w_k1_nxt;
            r_k2    <= w_k2_nxt;
        end
    end

    // Next-state, counter and event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise      = 1'b0;
        w_fall      = 1'b0;

        case (r_state)
            ST_LOW: begin
                if (a) begin
                    if (HOLD == 1) begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = ZERO_C;
                        w_rise      = 1'b1;
                    end else begin
                        w_state_nxt = ST_CHK_H;
                        w_cnt_nxt   = ONE_C;
                    end
                end
            end
            ST_CHK_H: begin
                if (!a) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = ZERO_C;
                end else if (w_done) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = ZERO_C;
                    w_rise      = 1'b1;
                end else if (r_cnt != HOLD_C) begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_HIGH: begin
                if (!a) begin
                    if (HOLD == 1) begin
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = ZERO_C;
                        w_fall      = 1'b1;
                    end else begin
                        w_state_nxt = ST_CHK_L;
                        w_cnt_nxt   = ONE_C;
                    end
                end
            end
            ST_CHK_L: begin
                if (a) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = ZERO_C;
                end else if (w_done) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = ZERO_C;
                    w_fall      = 1'b1;
                end else if (r_cnt != HOLD_C) begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = ZERO_C;
            end
        endcase

        // A new event always sets its bit, so it wins over a same-edge clear.
        w_k1_nxt = w_fall | (sticky & r_k1 & ~clr);
        w_k2_nxt = w_rise | (sticky & r_k2 & ~clr);
    end

    assign k1  = r_k1;
    assign k2  = r_k2;
    assign lvl = r_state[1];

endmodule

// File: rtl/edge_fsm_array.sv
// Array of independent debounce/transition-detect channels.
module edge_fsm_array #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned HOLD     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] a,
    input  logic                sticky,
    input  logic [CHANNELS-1:0] clr,
    output logic [CHANNELS-1:0] k1,
    output logic [CHANNELS-1:0] k2,
    output logic [CHANNELS-1:0] lvl
);

    // One identical FSM per input channel.
    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
        edge_fsm_chan #(
            .HOLD (HOLD)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .a      (a[i]),
            .sticky (sticky),
            .clr    (clr[i]),
            .k1     (k1[i]),
            .k2     (k2[i]),
            .lvl    (lvl[i])
        );
    end

endmodule
